// File: rtl/rst_sequencer.sv
// ---------------------------------------------------------------------------
// rst_sequencer
//   Brings the CSR, Ethernet, eCPRI and DSP domains out of reset in order.
//   Each release stage dwells a minimum number of cycles, the Ethernet stage
//   waits for eth_ready with a bounded timeout and limited retries, and the
//   block drops back to CSR_REL on link loss or a soft-reset request.
//
// Ports
//   clk_clk      : clock for all logic
//   reset_reset  : asynchronous active-high reset
//   sw_reset_req : soft-reset request (level, clk_clk domain)
//   eth_ready    : Ethernet link/PCS ready (already synchronised)
//   csr_rst_n    : CSR domain reset, active-low
//   eth_rst      : Ethernet domain reset, active-high
//   ecpri_rst    : eCPRI domain reset, active-high
//   dsp_rst      : DSP domain reset, active-high
//   seq_done     : high only in RUN
//   seq_fault    : high only in FAULT
//   link_drop    : one-cycle pulse when eth_ready is lost
//   retry_cnt    : ETH_WAIT timeouts seen in the current bring-up
//   seq_state    : current state encoding
// ---------------------------------------------------------------------------
module rst_sequencer #(
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned CNT_W          = 20
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       sw_reset_req,
    input  logic       eth_ready,
    output logic       csr_rst_n,
    output logic       eth_rst,
    output logic       ecpri_rst,
    output logic       dsp_rst,
    output logic       seq_done,
    output logic       seq_fault,
    output logic       link_drop,
    output logic [3:0] retry_cnt,
    output logic [2:0] seq_state
);

    localparam int unsigned STATE_W = 3;
    localparam int unsigned RETRY_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_ALL_RST   = 3'd0,
        ST_CSR_REL   = 3'd1,
        ST_ETH_WAIT  = 3'd2,
        ST_ECPRI_REL = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               arm_q;
    logic               enter;
    logic               hold_done;
    logic               timeout;

    logic csr_rst_n_q, csr_rst_n_d;
    logic eth_rst_q, eth_rst_d;
    logic ecpri_rst_q, ecpri_rst_d;
    logic dsp_rst_q, dsp_rst_d;
    logic seq_done_q, seq_done_d;
    logic seq_fault_q, seq_fault_d;
    logic link_drop_q, link_drop_d;

    assign hold_done = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
    assign timeout   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state, counter and retry logic
    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        enter       = 1'b0;
        link_drop_d = 1'b0;

        case (state_q)
            ST_ALL_RST: begin
                // Soft reset never re-asserts csr_rst_n, so it is ignored here
                if (arm_q && hold_done) begin
                    state_d = ST_CSR_REL;
                    enter   = 1'b1;
                end
            end
            ST_CSR_REL, ST_ETH_WAIT, ST_ECPRI_REL, ST_RUN, ST_FAULT: begin
                if (sw_reset_req) begin
                    // Soft reset wins over every other event in the same cycle
                    state_d = ST_CSR_REL;
                    retry_d = '0;
                    enter   = 1'b1;
                end else begin
                    case (state_q)
                        ST_CSR_REL: begin
                            if (hold_done) begin
                                state_d = ST_ETH_WAIT;
                                enter   = 1'b1;
                            end
                        end
                        ST_ETH_WAIT: begin
                            if (eth_ready) begin
                                state_d = ST_ECPRI_REL;
                                enter   = 1'b1;
                            end else if (timeout) begin
                                enter = 1'b1;
                                if (retry_q < RETRY_W'(MAX_RETRY)) begin
                                    retry_d = retry_q + RETRY_W'(1);
                                    state_d = ST_CSR_REL;
                                end else begin
                                    state_d = ST_FAULT;
                                end
                            end
                        end
                        ST_ECPRI_REL: begin
                            if (!eth_ready) begin
                                state_d     = ST_CSR_REL;
                                link_drop_d = 1'b1;
                                enter       = 1'b1;
                            end else if (hold_done) begin
                                state_d = ST_RUN;
                                retry_d = '0;
                                enter   = 1'b1;
                            end
                        end
                        ST_RUN: begin
                            if (!eth_ready) begin
                                state_d     = ST_CSR_REL;
                                link_drop_d = 1'b1;
                                enter       = 1'b1;
                            end
                        end
                        default: begin
                            // FAULT: only soft reset or hard reset leaves
                        end
                    endcase
                end
            end
            default: begin
                // Unused encodings recover through the full reset sequence
                state_d = ST_ALL_RST;
                retry_d = '0;
                enter   = 1'b1;
            end
        endcase

        // Counter restarts on every entry; saturates so long RUN/FAULT stays never wrap
        if (enter) begin
            cnt_d = '0;
        end else if (arm_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output decode from the next state so outputs change on the entry edge
    always_comb begin
        csr_rst_n_d = 1'b1;
        eth_rst_d   = 1'b1;
        ecpri_rst_d = 1'b1;
        dsp_rst_d   = 1'b1;
        seq_done_d  = 1'b0;
        seq_fault_d = 1'b0;
        case (state_d)
            ST_ALL_RST: begin
                csr_rst_n_d = 1'b0;
            end
            ST_CSR_REL: begin
            end
            ST_ETH_WAIT: begin
                eth_rst_d = 1'b0;
            end
            ST_ECPRI_REL: begin
                eth_rst_d   = 1'b0;
                ecpri_rst_d = 1'b0;
            end
            ST_RUN: begin
                eth_rst_d   = 1'b0;
                ecpri_rst_d = 1'b0;
                dsp_rst_d   = 1'b0;
                seq_done_d  = 1'b1;
            end
            ST_FAULT: begin
                seq_fault_d = 1'b1;
            end
            default: begin
                csr_rst_n_d = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs. The first edge after reset
    // deassertion only arms the sequencer, so ALL_RST counts from a clean edge.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= ST_ALL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            arm_q       <= 1'b0;
            csr_rst_n_q <= 1'b0;
            eth_rst_q   <= 1'b1;
            ecpri_rst_q <= 1'b1;
            dsp_rst_q   <= 1'b1;
            seq_done_q  <= 1'b0;
            seq_fault_q <= 1'b0;
            link_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            arm_q       <= 1'b1;
            csr_rst_n_q <= csr_rst_n_d;
            eth_rst_q   <= eth_rst_d;
            ecpri_rst_q <= ecpri_rst_d;
            dsp_rst_q   <= dsp_rst_d;
            seq_done_q  <= seq_done_d;
            seq_fault_q <= seq_fault_d;
            link_drop_q <= link_drop_d;
        end
    end

    assign csr_rst_n = csr_rst_n_q;
    assign eth_rst   = eth_rst_q;
    assign ecpri_rst = ecpri_rst_q;
    assign dsp_rst   = dsp_rst_q;
    assign seq_done  = seq_done_q;
    assign seq_fault = seq_fault_q;
    assign link_drop = link_drop_q;
    assign retry_cnt = retry_q;
    assign seq_state = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rst_sequencer
//   Self-checking bench for rst_sequencer with HOLD_CYCLES=4,
//   TIMEOUT_CYCLES=32, MAX_RETRY=2. Cycle 0 is the first clock edge after
//   reset release; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_rst_sequencer;

    logic       clk_clk;
    logic       reset_reset;
    logic       sw_reset_req;
    logic       eth_ready;
    logic       csr_rst_n;
    logic       eth_rst;
    logic       ecpri_rst;
    logic       dsp_rst;
    logic       seq_done;
    logic       seq_fault;
    logic       link_drop;
    logic [3:0] retry_cnt;
    logic [2:0] seq_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = -1;

    rst_sequencer #(
        .HOLD_CYCLES   (4),
        .TIMEOUT_CYCLES(32),
        .MAX_RETRY     (2),
        .CNT_W         (8)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .sw_reset_req(sw_reset_req),
        .eth_ready   (eth_ready),
        .csr_rst_n   (csr_rst_n),
        .eth_rst     (eth_rst),
        .ecpri_rst   (ecpri_rst),
        .dsp_rst     (dsp_rst),
        .seq_done    (seq_done),
        .seq_fault   (seq_fault),
        .link_drop   (link_drop),
        .retry_cnt   (retry_cnt),
        .seq_state   (seq_state)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    typedef struct {
        logic       sw;
        logic       eth;
        logic [2:0] st;
        logic       ld;
        logic [3:0] rt;
    } vec_t;

    vec_t tbl[$];

    // Expected {csr_rst_n,eth,ecpri,dsp,done,fault,link_drop,retry,state}
    function automatic logic [13:0] exp_vec(input logic [2:0] st, input logic ld,
                                            input logic [3:0] rt);
        logic [5:0] dec;
        case (st)
            3'd0:    dec = 6'b0111_00;
            3'd1:    dec = 6'b1111_00;
            3'd2:    dec = 6'b1011_00;
            3'd3:    dec = 6'b1001_00;
            3'd4:    dec = 6'b1000_10;
            3'd5:    dec = 6'b1111_01;
            default: dec = 6'b0111_00;
        endcase
        return {dec, ld, rt, st};
    endfunction

    function automatic logic [13:0] got_vec();
        return {csr_rst_n, eth_rst, ecpri_rst, dsp_rst, seq_done, seq_fault,
                link_drop, retry_cnt, seq_state};
    endfunction

    task automatic chk(input string nm, input logic [13:0] exp);
        logic [13:0] got;
        got = got_vec();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        cyc++;
        @(negedge clk_clk);
    endtask

    task automatic check_at(input int k, input string nm, input logic [2:0] st,
                            input logic [3:0] rt);
        int guard;
        guard = 0;
        while (cyc < k && guard < 1000) begin
            tick();
            guard++;
        end
        chk(nm, exp_vec(st, 1'b0, rt));
    endtask

    task automatic add(input logic sw, input logic eth, input logic [2:0] st,
                       input logic ld, input int n);
        vec_t v;
        v.sw  = sw;
        v.eth = eth;
        v.st  = st;
        v.ld  = ld;
        v.rt  = 4'd0;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    // Assert reset across an edge, release on a falling edge
    task automatic hard_reset(input logic eth);
        @(negedge clk_clk);
        reset_reset = 1'b1;
        tick();
        tick();
        sw_reset_req = 1'b0;
        eth_ready    = eth;
        reset_reset  = 1'b0;
        cyc          = -1;
    endtask

    initial begin
        reset_reset  = 1'b1;
        sw_reset_req = 1'b0;
        eth_ready    = 1'b1;

        // Bring-up, link drop in RUN, soft reset priority and hold, sw+eth race
        add(0, 1, 3'd0, 0, 4);   // cycles 0-3
        add(0, 1, 3'd1, 0, 4);   // 4-7
        add(0, 1, 3'd2, 0, 1);   // 8
        add(0, 1, 3'd3, 0, 4);   // 9-12
        add(0, 1, 3'd4, 0, 2);   // 13-14
        add(0, 0, 3'd1, 1, 1);   // 15 link drop
        add(0, 1, 3'd1, 0, 3);   // 16-18
        add(0, 1, 3'd2, 0, 1);   // 19
        add(0, 1, 3'd3, 0, 4);   // 20-23
        add(0, 1, 3'd4, 0, 1);   // 24
        add(1, 0, 3'd1, 0, 1);   // 25 soft reset beats link drop
        add(1, 1, 3'd1, 0, 2);   // 26-27 held soft reset
        add(0, 1, 3'd1, 0, 3);   // 28-30
        add(0, 1, 3'd2, 0, 1);   // 31
        add(1, 1, 3'd1, 0, 1);   // 32 soft reset beats eth_ready
        add(0, 1, 3'd1, 0, 3);   // 33-35
        add(0, 1, 3'd2, 0, 1);   // 36
        add(0, 1, 3'd3, 0, 1);   // 37

        #23;
        chk("in_reset", exp_vec(3'd0, 1'b0, 4'd0));
        @(negedge clk_clk);
        chk("in_reset_late", exp_vec(3'd0, 1'b0, 4'd0));
        reset_reset = 1'b0;
        cyc = -1;

        for (int i = 0; i < tbl.size(); i++) begin
            sw_reset_req = tbl[i].sw;
            eth_ready    = tbl[i].eth;
            tick();
            chk($sformatf("vec%0d", i), exp_vec(tbl[i].st, tbl[i].ld, tbl[i].rt));
        end

        // Asynchronous reset between edges while in ECPRI_REL
        #2 reset_reset = 1'b1;
        #1 chk("async_rst", exp_vec(3'd0, 1'b0, 4'd0));
        @(negedge clk_clk);
        reset_reset  = 1'b0;
        sw_reset_req = 1'b1;
        eth_ready    = 1'b1;
        cyc          = -1;
        check_at(3, "rerun_allrst_swign", 3'd0, 4'd0);
        sw_reset_req = 1'b0;
        check_at(4, "rerun_csr", 3'd1, 4'd0);
        check_at(7, "rerun_csr_end", 3'd1, 4'd0);
        check_at(8, "rerun_eth", 3'd2, 4'd0);
        check_at(9, "rerun_ecpri", 3'd3, 4'd0);
        check_at(12, "rerun_ecpri_end", 3'd3, 4'd0);
        check_at(13, "rerun_run", 3'd4, 4'd0);

        // eth_ready stuck low: two retries then FAULT, recovered by soft reset
        hard_reset(1'b0);
        check_at(8, "to_eth_wait", 3'd2, 4'd0);
        check_at(39, "win1_end", 3'd2, 4'd0);
        check_at(40, "retry1", 3'd1, 4'd1);
        check_at(43, "retry1_csr", 3'd1, 4'd1);
        check_at(44, "win2", 3'd2, 4'd1);
        check_at(75, "win2_end", 3'd2, 4'd1);
        check_at(76, "retry2", 3'd1, 4'd2);
        check_at(111, "win3_end", 3'd2, 4'd2);
        check_at(112, "fault", 3'd5, 4'd2);
        check_at(120, "fault_hold", 3'd5, 4'd2);
        sw_reset_req = 1'b1;
        check_at(121, "fault_exit", 3'd1, 4'd0);
        sw_reset_req = 1'b0;
        eth_ready    = 1'b1;
        check_at(125, "post_fault_eth", 3'd2, 4'd0);
        check_at(129, "post_fault_ecpri", 3'd3, 4'd0);
        check_at(130, "post_fault_run", 3'd4, 4'd0);

        // One timeout, then success: retry_cnt clears on RUN entry
        hard_reset(1'b0);
        check_at(40, "r5_retry1", 3'd1, 4'd1);
        eth_ready = 1'b1;
        check_at(44, "r5_eth", 3'd2, 4'd1);
        check_at(45, "r5_ecpri", 3'd3, 4'd1);
        check_at(48, "r5_ecpri_end", 3'd3, 4'd1);
        check_at(49, "r5_run", 3'd4, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
